// File: rtl/shift_request_arbiter_if.sv
// Command channel between the shift request arbiter and the gearbox FSM.
// The arbiter is the master and drives cmd_valid/cmd. The gearbox is the slave and answers with cmd_ready.
interface shift_request_arbiter_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;

  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ready
  );
endinterface

// File: rtl/shift_request_arbiter.sv
// Conditions raw driver shift/brake inputs, arbitrates brake > down > up, and enforces gear limits and dwell.
// cmd_valid rises SYNC_STAGES+3 clk edges after a raw rising input when idle; cmd is held until cmd_ready.
module shift_request_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int DWELL_TICKS = 4,
  parameter int MAX_GEAR    = 5,
  parameter int GEAR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  shift_up,
  input  logic                  shift_down,
  input  logic                  brake,
  shift_request_arbiter_if.master cmd_if,
  output logic [GEAR_W-1:0]     gear,
  output logic                  busy,
  output logic                  dropped
);

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_BRK  = 2'b11;
  localparam int CNT_W = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_up_sync;
  logic [SYNC_STAGES-1:0] r_dn_sync;
  logic [SYNC_STAGES-1:0] r_brk_sync;
  logic                   r_up_prev;
  logic                   r_dn_prev;
  logic                   r_brk_prev;
  logic                   r_up_e;
  logic                   r_dn_e;
  logic                   r_brk_e;

  logic                   w_up_s;
  logic                   w_dn_s;
  logic                   w_brk_s;

  state_t                 r_state;
  logic                   r_pend_up;
  logic                   r_pend_dn;
  logic                   r_pend_brk;
  logic                   r_cmd_vld;
  logic [1:0]             r_cmd;
  logic [GEAR_W-1:0]      r_gear;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_dropped;

  logic                   w_clr_up;
  logic                   w_clr_dn;
  logic                   w_clr_brk;
  logic                   w_lim_drop;
  logic                   w_sel_vld;
  logic [1:0]             w_sel_cmd;
  logic                   w_pend_up_n;
  logic                   w_pend_dn_n;
  logic                   w_pend_brk_n;
  logic                   w_in_drop;

  assign w_up_s  = r_up_sync[SYNC_STAGES-1];
  assign w_dn_s  = r_dn_sync[SYNC_STAGES-1];
  assign w_brk_s = r_brk_sync[SYNC_STAGES-1];

  // Synchronizers followed by registered rising-edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_sync  <= '0;
      r_dn_sync  <= '0;
      r_brk_sync <= '0;
      r_up_prev  <= 1'b0;
      r_dn_prev  <= 1'b0;
      r_brk_prev <= 1'b0;
      r_up_e     <= 1'b0;
      r_dn_e     <= 1'b0;
      r_brk_e    <= 1'b0;
    end else begin
      r_up_sync  <= {r_up_sync[SYNC_STAGES-2:0], shift_up};
      r_dn_sync  <= {r_dn_sync[SYNC_STAGES-2:0], shift_down};
      r_brk_sync <= {r_brk_sync[SYNC_STAGES-2:0], brake};
      r_up_prev  <= w_up_s;
      r_dn_prev  <= w_dn_s;
      r_brk_prev <= w_brk_s;
      r_up_e     <= w_up_s & ~r_up_prev;
      r_dn_e     <= w_dn_s & ~r_dn_prev;
      r_brk_e    <= w_brk_s & ~r_brk_prev;
    end
  end

  // Selection in IDLE; a request that would leave the gear range is consumed and reported as dropped.
  always_comb begin
    w_clr_up   = 1'b0;
    w_clr_dn   = 1'b0;
    w_clr_brk  = 1'b0;
    w_lim_drop = 1'b0;
    w_sel_vld  = 1'b0;
    w_sel_cmd  = CMD_NONE;
    if (r_state == ST_IDLE) begin
      if (r_pend_brk) begin
        w_clr_brk = 1'b1;
        w_sel_vld = 1'b1;
        w_sel_cmd = CMD_BRK;
      end else if (r_pend_dn) begin
        w_clr_dn = 1'b1;
        if (r_gear == '0) begin
          w_lim_drop = 1'b1;
        end else begin
          w_sel_vld = 1'b1;
          w_sel_cmd = CMD_DOWN;
        end
      end else if (r_pend_up) begin
        w_clr_up = 1'b1;
        if (r_gear == GEAR_W'(MAX_GEAR)) begin
          w_lim_drop = 1'b1;
        end else begin
          w_sel_vld = 1'b1;
          w_sel_cmd = CMD_UP;
        end
      end
    end
  end

  // New edges are applied after the arbiter's consumption, so a fresh request is never lost to a clear.
  always_comb begin
    w_pend_up_n  = r_pend_up  & ~w_clr_up;
    w_pend_dn_n  = r_pend_dn  & ~w_clr_dn;
    w_pend_brk_n = r_pend_brk & ~w_clr_brk;
    w_in_drop    = 1'b0;
    if (r_brk_e) begin
      w_pend_brk_n = 1'b1;
      w_pend_up_n  = 1'b0;
      w_pend_dn_n  = 1'b0;
    end
    if (r_up_e && r_dn_e) begin
      w_in_drop = 1'b1;
    end else if (r_up_e) begin
      if (w_brk_s || w_pend_up_n) begin
        w_in_drop = 1'b1;
      end else begin
        w_pend_up_n = 1'b1;
        w_pend_dn_n = 1'b0;
      end
    end else if (r_dn_e) begin
      if (w_pend_dn_n) begin
        w_in_drop = 1'b1;
      end else begin
        w_pend_dn_n = 1'b1;
        w_pend_up_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pend_up  <= 1'b0;
      r_pend_dn  <= 1'b0;
      r_pend_brk <= 1'b0;
      r_cmd_vld  <= 1'b0;
      r_cmd      <= CMD_NONE;
      r_gear     <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_pend_up  <= w_pend_up_n;
      r_pend_dn  <= w_pend_dn_n;
      r_pend_brk <= w_pend_brk_n;
      r_dropped  <= w_in_drop | w_lim_drop;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_vld) begin
            r_cmd_vld <= 1'b1;
            r_cmd     <= w_sel_cmd;
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_if.cmd_ready) begin
            r_cmd_vld <= 1'b0;
            r_cmd     <= CMD_NONE;
            case (r_cmd)
              CMD_UP:   r_gear <= r_gear + GEAR_W'(1);
              CMD_DOWN: r_gear <= r_gear - GEAR_W'(1);
              CMD_BRK: begin
                if (r_gear > GEAR_W'(1)) begin
                  r_gear <= GEAR_W'(1);
                end
              end
              default: r_gear <= r_gear;
            endcase
            if (DWELL_TICKS == 0) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= CNT_W'(DWELL_TICKS);
              r_state <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          if (tick) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_cmd_vld <= 1'b0;
          r_cmd     <= CMD_NONE;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_if.cmd_valid = r_cmd_vld;
  assign cmd_if.cmd       = r_cmd;
  assign gear             = r_gear;
  assign busy             = r_busy;
  assign dropped          = r_dropped;

endmodule

// File: tb/tb_shift_request_arbiter.sv
// Directed bench for shift_request_arbiter: latency, limits, handshake hold, brake cancel, conflicts, async reset.
module tb_shift_request_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       shift_up;
  logic       shift_down;
  logic       brake;
  logic [2:0] gear;
  logic       busy;
  logic       dropped;

  int n_cmp = 0;
  int n_err = 0;
  int vc;
  int dc;
  logic [1:0] cs;
  logic bad;

  shift_request_arbiter_if cmd_if ();

  shift_request_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .shift_up   (shift_up),
    .shift_down (shift_down),
    .brake      (brake),
    .cmd_if     (cmd_if.master),
    .gear       (gear),
    .busy       (busy),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic u, input logic d);
    shift_up   = u;
    shift_down = d;
    cyc(1);
    shift_up   = 1'b0;
    shift_down = 1'b0;
  endtask

  task automatic do_shift(input logic u, input logic d);
    pulse(u, d);
    cyc(12);
  endtask

  // Counts valid and dropped cycles over a window and ORs together every cmd seen while valid.
  task automatic watch(input int n, output int v_cnt, output int d_cnt, output logic [1:0] c_seen);
    v_cnt  = 0;
    d_cnt  = 0;
    c_seen = 2'b00;
    repeat (n) begin
      cyc(1);
      if (cmd_if.cmd_valid === 1'b1) begin
        v_cnt++;
        c_seen = c_seen | cmd_if.cmd;
      end
      if (dropped === 1'b1) d_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    shift_up = 1'b0;
    shift_down = 1'b0;
    brake = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    cyc(2);
    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_cmd", cmd_if.cmd, 0);
    check("rst_gear", gear, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    cyc(3);
    check("post_rst_valid", cmd_if.cmd_valid, 0);
    check("post_rst_busy", busy, 0);

    // Single UP with ready tied high: valid for one cycle, 5 edges after the raw edge.
    cmd_if.cmd_ready = 1'b1;
    pulse(1'b1, 1'b0);
    cyc(3);
    check("t1_valid_k4", cmd_if.cmd_valid, 0);
    cyc(1);
    check("t1_valid_k5", cmd_if.cmd_valid, 1);
    check("t1_cmd_k5", cmd_if.cmd, 2'b01);
    check("t1_gear_k5", gear, 0);
    check("t1_busy_k5", busy, 1);
    cyc(1);
    check("t1_valid_k6", cmd_if.cmd_valid, 0);
    check("t1_cmd_k6", cmd_if.cmd, 0);
    check("t1_gear_k6", gear, 1);
    check("t1_busy_k6", busy, 1);
    repeat (3) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
    check("t1_busy_3ticks", busy, 1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("t1_busy_4ticks", busy, 0);

    // Climb to the top gear, then try to exceed it.
    tick = 1'b1;
    repeat (4) do_shift(1'b1, 1'b0);
    check("t2_gear_top", gear, 5);
    pulse(1'b1, 1'b0);
    watch(12, vc, dc, cs);
    check("t2_top_valid", vc, 0);
    check("t2_top_drop", dc, 1);
    check("t2_top_gear", gear, 5);
    repeat (5) do_shift(1'b0, 1'b1);
    check("t2_gear_neutral", gear, 0);
    pulse(1'b0, 1'b1);
    watch(12, vc, dc, cs);
    check("t2_bot_valid", vc, 0);
    check("t2_bot_drop", dc, 1);
    check("t2_bot_gear", gear, 0);

    // Gearbox stalls for 10 cycles: command must stay put and gear must not move.
    cmd_if.cmd_ready = 1'b0;
    pulse(1'b1, 1'b0);
    cyc(4);
    bad = 1'b0;
    repeat (10) begin
      if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd !== 2'b01 || gear !== 3'd0) bad = 1'b1;
      cyc(1);
    end
    check("t3_stable_hold", bad, 0);
    check("t3_still_valid", cmd_if.cmd_valid, 1);
    check("t3_gear_pre", gear, 0);
    cmd_if.cmd_ready = 1'b1;
    cyc(1);
    check("t3_gear_xfer", gear, 1);
    check("t3_valid_xfer", cmd_if.cmd_valid, 0);
    cyc(6);

    // Brake during hold-off cancels a pending UP and forces gear 1.
    do_shift(1'b1, 1'b0);
    tick = 1'b0;
    pulse(1'b1, 1'b0);
    cyc(5);
    check("t4_gear3", gear, 3);
    check("t4_busy_hold", busy, 1);
    pulse(1'b1, 1'b0);
    cyc(5);
    brake = 1'b1;
    cyc(7);
    tick = 1'b1;
    watch(14, vc, dc, cs);
    check("t4_brk_count", vc, 1);
    check("t4_brk_cmd", cs, 2'b11);
    check("t4_brk_gear", gear, 1);
    check("t4_brk_idle", busy, 0);
    pulse(1'b1, 1'b0);
    watch(10, vc, dc, cs);
    check("t4_up_braked_valid", vc, 0);
    check("t4_up_braked_drop", dc, 1);
    check("t4_up_braked_gear", gear, 1);
    pulse(1'b0, 1'b1);
    watch(12, vc, dc, cs);
    check("t4_down_braked_count", vc, 1);
    check("t4_down_braked_cmd", cs, 2'b10);
    check("t4_down_braked_gear", gear, 0);
    brake = 1'b0;
    cyc(4);

    // Simultaneous up/down is discarded; a later DOWN overrides a pending UP.
    do_shift(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    watch(10, vc, dc, cs);
    check("t5_both_valid", vc, 0);
    check("t5_both_drop", dc, 1);
    check("t5_both_gear", gear, 1);
    tick = 1'b0;
    pulse(1'b1, 1'b0);
    cyc(5);
    check("t5_gear2", gear, 2);
    pulse(1'b1, 1'b0);
    cyc(5);
    pulse(1'b0, 1'b1);
    cyc(5);
    tick = 1'b1;
    watch(14, vc, dc, cs);
    check("t5_override_count", vc, 1);
    check("t5_override_cmd", cs, 2'b10);
    check("t5_override_gear", gear, 1);
    check("t5_override_drop", dc, 0);

    // Asynchronous reset in the middle of a stalled handshake.
    do_shift(1'b1, 1'b0);
    check("t6_gear2", gear, 2);
    cmd_if.cmd_ready = 1'b0;
    pulse(1'b1, 1'b0);
    cyc(4);
    check("t6_valid_pre", cmd_if.cmd_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", cmd_if.cmd_valid, 0);
    check("t6_async_cmd", cmd_if.cmd, 0);
    check("t6_async_gear", gear, 0);
    check("t6_async_busy", busy, 0);
    cyc(2);
    cmd_if.cmd_ready = 1'b1;
    rst_n = 1'b1;
    watch(8, vc, dc, cs);
    check("t6_no_complete", vc, 0);
    check("t6_gear_after", gear, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
